fix2ieee: RTL
=============

# fix2ieee

Converts one signed fixed-point CORDIC result, plus the power-of-two scale from range reduction, into an IEEE-754 single-precision word. It sits directly downstream of the hyperbolic CORDIC core, one instance per output channel (e^x, sinh x, cosh x). The CORDIC result is value = fix_in · 2^-FRAC_W · 2^exp_in. It is a three-state sequential converter with an en/valid pulse handshake, matching the top-level IEEE wrapper.

## Interface
- FIX_W, 32, width of two's-complement fixed-point input
- FRAC_W, 28, fractional bits of fix_in (default Q4.28)
- EXP_W, 10, width of signed scale input exp_in
- clk  in  1  rising-edge clock
- rst  in  1  reset; single clock, reset is asynchronous and active-low
- en  in  1  start request; sampled only while busy=0
- fix_in  in  FIX_W  signed fixed-point operand
- exp_in  in  EXP_W  signed power-of-two scale (two's complement)
- ieee_out  out  32  IEEE-754 single result; holds until next result
- valid  out  1  one-cycle pulse, ieee_out/flags updated
- busy  out  1  conversion in flight; en ignored
- ovf  out  1  result saturated to ±inf (qualified by valid, held with ieee_out)
- unf  out  1  result flushed to ±0 (qualified by valid, held with ieee_out)

## Operation
- States: IDLE, NORM, ROUND. Reset (rst=0, async) forces IDLE, ieee_out=0, valid=0, busy=0, ovf=0, unf=0. An in-flight conversion is discarded with no valid.
- IDLE: on edge with en=1:
  - register sign=fix_in[FIX_W-1], mag=|fix_in| as unsigned FIX_W bits (−2^(FIX_W-1) maps to 2^(FIX_W-1), exact), and exp_in
  - busy<=1, go NORM
- NORM:
  - lz = leading-zero count of mag
  - register norm = mag << lz, so leading 1 is at bit FIX_W-1
  - register E = (FIX_W-1-lz) − FRAC_W + exp_in + 127, in EXP_W+2 signed bits (no wrap)
  - register zero = (mag==0)
  - go ROUND
- ROUND:
  - frac = norm[FIX_W-2 -: 23]; guard = next bit; sticky = OR of remaining bits
  - round-to-nearest-even: increment when guard & (sticky | frac[0])
  - carry out of frac: frac=0, E+=1
  - pack: zero → 0x00000000, ovf=unf=0 (sign forced 0); E≥255 → {sign,8'hFF,23'h0}, ovf=1; E≤0 → {sign,31'h0}, unf=1 (no subnormals); else {sign,E[7:0],frac}
  - valid<=1, busy<=0, go IDLE
- valid is high for exactly the cycle after the ROUND edge. en high in that cycle starts the next conversion (back-to-back throughput 1 per 3 cycles). en held high continuously restarts on every IDLE edge.
- Inputs are sampled only on the IDLE capture edge; later changes have no effect.

## Timing
- Latency: en captured at edge N → ieee_out/valid/ovf/unf registered at edge N+2, visible in cycle N+2..N+3
- busy high from after edge N until after edge N+2
- Every output is a register; nothing is combinational from an input to an output.

## Structure
- Shared package cordic_pkg holds: IEEE_BIAS=127, IEEE_EXP_MAX=255, IEEE_MANT_W=23, IEEE_POS_INF=32'h7F800000, and the state enum (IDLE/NORM/ROUND).
- One sub-module, lzc, is parameterized on width and purely combinational. It returns the count, with count=WIDTH for all-zero input.
- The top wrapper instantiates three fix2ieee instances and ANDs their valids.

## Test plan
- fix_in=0x10000000 (1.0), exp_in=0 → ieee_out=0x3F800000, valid 3 edges after en, ovf=unf=0.
- fix_in=0x18000000 (1.5), exp_in=5 → 0x42400000 (48.0). fix_in=0xF0000000 (−1.0), exp_in=0 → 0xBF800000. fix_in=0x80000000, exp_in=0 → 0xC1000000 (−8.0).
- Rounding, exp_in=0:
  - 0x10000008 → 0x3F800000 (sticky only)
  - 0x10000010 → 0x3F800000 (tie, even)
  - 0x10000030 → 0x3F800002 (tie, odd up)
  - 0x1FFFFFF0 → 0x40000000 (mantissa carry)
- Exceptions:
  - fix_in=0 → 0x00000000
  - 0x10000000 with exp_in=200 → 0x7F800000, ovf=1
  - 0xF0000000 with exp_in=−127 → 0x80000000, unf=1
- Handshake: en held high 4 cycles → conversions start at edges 0 and 3. en pulsed while busy → ignored. en raised in the valid cycle → next result exactly 3 edges later.
- Reset: assert rst=0 in NORM → all outputs 0 immediately, no valid pulse. After release, a fresh 1.0 conversion returns 0x3F800000.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC IEEE-754 output stage.
package cordic_pkg;

    localparam int unsigned IEEE_BIAS    = 127;
    localparam int unsigned IEEE_EXP_MAX = 255;
    localparam int unsigned IEEE_MANT_W  = 23;
    localparam logic [31:0] IEEE_POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND
    } state_e;

endpackage

// File: rtl/fix2ieee_if.sv
// Start/result handshake between a CORDIC channel and its fixed-to-IEEE converter.
interface fix2ieee_if #(
    parameter int unsigned FIX_W = 32,
    parameter int unsigned EXP_W = 10
);

    logic             en;
    logic [FIX_W-1:0] fix_in;
    logic [EXP_W-1:0] exp_in;
    logic [31:0]      ieee_out;
    logic             valid;
    logic             busy;
    logic             ovf;
    logic             unf;

    modport master (
        output en, fix_in, exp_in,
        input  ieee_out, valid, busy, ovf, unf
    );

    modport slave (
        input  en, fix_in, exp_in,
        output ieee_out, valid, busy, ovf, unf
    );

endinterface

// File: rtl/fix2ieee_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module lzc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fix2ieee.sv
// Three-state converter: signed fixed-point value scaled by 2^exp_in -> IEEE-754 single,
// round-to-nearest-even, saturating to +/-inf and flushing to +/-0.
module fix2ieee
    import cordic_pkg::*;
#(
    parameter int unsigned FIX_W  = 32,
    parameter int unsigned FRAC_W = 28,
    parameter int unsigned EXP_W  = 10
) (
    input  logic       clk,
    input  logic       rst,
    fix2ieee_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(FIX_W + 1);
    localparam int unsigned E_W   = EXP_W + 2;

    state_e                state_q, state_d;
    logic                  sign_q, sign_d;
    logic [FIX_W-1:0]      mag_q, mag_d;
    logic [EXP_W-1:0]      exp_q, exp_d;
    logic [FIX_W-1:0]      norm_q, norm_d;
    logic signed [E_W-1:0] e_q, e_d;
    logic                  zero_q, zero_d;
    logic [31:0]           ieee_q, ieee_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [CNT_W-1:0]         lz;
    logic [IEEE_MANT_W-1:0]   frac;
    logic                     guard;
    logic                     sticky;
    logic                     round_up;
    logic [IEEE_MANT_W:0]     frac_rnd;
    logic signed [E_W-1:0]    e_rnd;
    logic                     e_big;
    logic                     e_small;

    lzc #(
        .WIDTH (FIX_W)
    ) u_lzc (
        .data  (mag_q),
        .count (lz)
    );

    // Rounding datapath works on the normalised magnitude held in ROUND.
    assign frac     = norm_q[FIX_W-2 -: IEEE_MANT_W];
    assign guard    = norm_q[FIX_W-2-IEEE_MANT_W];
    assign sticky   = |norm_q[FIX_W-3-IEEE_MANT_W:0];
    assign round_up = guard & (sticky | frac[0]);
    assign frac_rnd = {1'b0, frac} + {{IEEE_MANT_W{1'b0}}, round_up};
    assign e_rnd    = e_q + $signed({{(E_W-1){1'b0}}, frac_rnd[IEEE_MANT_W]});
    assign e_big    = e_rnd >= $signed(E_W'(IEEE_EXP_MAX));
    assign e_small  = e_rnd[E_W-1] || (e_rnd == '0);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        norm_d  = norm_q;
        e_d     = e_q;
        zero_d  = zero_q;
        ieee_d  = ieee_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    sign_d  = bus.fix_in[FIX_W-1];
                    // Negating the most negative code wraps to 2^(FIX_W-1), which is exact
                    // when read back as unsigned.
                    mag_d   = bus.fix_in[FIX_W-1] ? -bus.fix_in : bus.fix_in;
                    exp_d   = bus.exp_in;
                    busy_d  = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                norm_d  = mag_q << lz;
                e_d     = $signed(E_W'(FIX_W - 1 - FRAC_W + IEEE_BIAS))
                        - $signed(E_W'(lz))
                        + $signed({{2{exp_q[EXP_W-1]}}, exp_q});
                zero_d  = (mag_q == '0);
                state_d = ROUND;
            end
            ROUND: begin
                if (zero_q) begin
                    ieee_d = 32'h0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                end else if (e_big) begin
                    ieee_d = {sign_q, IEEE_POS_INF[30:0]};
                    ovf_d  = 1'b1;
                    unf_d  = 1'b0;
                end else if (e_small) begin
                    ieee_d = {sign_q, 31'h0};
                    ovf_d  = 1'b0;
                    unf_d  = 1'b1;
                end else begin
                    ieee_d = {sign_q, e_rnd[7:0], frac_rnd[IEEE_MANT_W-1:0]};
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            norm_q  <= '0;
            e_q     <= '0;
            zero_q  <= 1'b0;
            ieee_q  <= 32'h0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            norm_q  <= norm_d;
            e_q     <= e_d;
            zero_q  <= zero_d;
            ieee_q  <= ieee_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.ieee_out = ieee_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;

endmodule
